// File: rtl/not_u_delay.sv
// Clocked inverter with separate rise/fall delays in clock cycles and inertial pulse filtering.
// Define NOT_U_VAR_DLY_EN to take delays from the rise_dly/fall_dly ports instead of parameters.
module not_u_delay #(
  parameter int unsigned DLY_W    = 8,
  parameter int unsigned RISE_DLY = 11,
  parameter int unsigned FALL_DLY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
`ifdef NOT_U_VAR_DLY_EN
  input  logic [DLY_W-1:0] rise_dly,
  input  logic [DLY_W-1:0] fall_dly,
`endif
  output logic             out,
  output logic             pending
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             out_q, out_d;
  logic             pend_val_q, pend_val_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             tgt;
  logic [DLY_W-1:0] rise_d, fall_d, dly_sel;

`ifdef NOT_U_VAR_DLY_EN
  assign rise_d = rise_dly;
  assign fall_d = fall_dly;
`else
  assign rise_d = DLY_W'(RISE_DLY);
  assign fall_d = DLY_W'(FALL_DLY);
`endif

  assign tgt     = ~in;
  assign dly_sel = tgt ? rise_d : fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_q      <= 1'b0;
      pend_val_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      pend_val_q <= pend_val_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    pend_val_d = pend_val_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tgt != out_q) begin
          if (dly_sel == '0) begin
            out_d = tgt;
          end else begin
            state_d    = ST_PEND;
            pend_val_d = tgt;
            cnt_d      = dly_sel - DLY_W'(1);
          end
        end
      end
      ST_PEND: begin
        // A target mismatch here means the input returned to match out: drop the pulse.
        if (tgt == pend_val_q) begin
          if (cnt_q == '0) begin
            out_d   = pend_val_q;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out     = out_q;
  assign pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_not_u_delay.sv
// Self-checking bench for not_u_delay: table-driven per-edge vectors plus reset/variable-delay sequences.
module tb_not_u_delay;

  localparam int unsigned DLY_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in = 1'b1;
  logic out, pending;
`ifdef NOT_U_VAR_DLY_EN
  logic [DLY_W-1:0] rise_dly = 8'd11;
  logic [DLY_W-1:0] fall_dly = 8'd0;
`endif

  not_u_delay #(.DLY_W(DLY_W), .RISE_DLY(11), .FALL_DLY(0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
`ifdef NOT_U_VAR_DLY_EN
    .rise_dly(rise_dly),
    .fall_dly(fall_dly),
`endif
    .out(out),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic in;
    logic exp_out;
    logic exp_pend;
  } vec_t;

  typedef struct {
    logic exp_out;
    logic exp_pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic i, input logic o, input logic p, input int unsigned reps);
    vec_t v;
    v.in = i; v.exp_out = o; v.exp_pend = p;
    for (int unsigned k = 0; k < reps; k++) vecs.push_back(v);
  endtask

  // Drive one input level across one rising edge and compare against the queued expectation.
  task automatic step(input logic i, input logic o, input logic p, input string name);
    exp_t e;
    in = i;
    e.exp_out = o; e.exp_pend = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, ".out"}, out, e.exp_out);
      check({name, ".pending"}, pending, e.exp_pend);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    // Rise D=11, fall D=0
    add(1, 0, 0, 3);   // idle after reset
    add(0, 0, 1, 11);  // rise countdown edges 1..11
    add(0, 1, 0, 2);   // out rises on edge 12
    add(1, 0, 0, 2);   // fall immediate, never pending
    add(0, 0, 1, 5);   // 5-cycle pulse
    add(1, 0, 0, 2);   // cancelled on return edge
    add(0, 0, 1, 11);  // pulse of exactly D edges
    add(1, 0, 0, 1);   // still absorbed
    add(0, 0, 1, 11);
    add(0, 1, 0, 1);   // D+1 edges passes
    add(1, 0, 0, 1);   // back-to-back fall on next edge
    add(0, 0, 1, 1);   // and a new rise schedules immediately
    add(1, 0, 0, 2);

    in = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", out, 1'b0);
    check("reset.pending", pending, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].in, vecs[i].exp_out, vecs[i].exp_pend, $sformatf("vec%0d", i));

    // Reset during cycle 6 of the rise countdown
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, "rstmid.pre");
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid.async.out", out, 1'b0);
    check("rstmid.async.pending", pending, 1'b0);
    @(posedge clk);
    #1;
    check("rstmid.held.pending", pending, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b1, "rstmid.post");
    step(1'b0, 1'b1, 1'b0, "rstmid.rise");
    step(1'b1, 1'b0, 1'b0, "rstmid.fall");

`ifdef NOT_U_VAR_DLY_EN
    rise_dly = 8'd3;
    fall_dly = 8'd2;
    for (int i = 0; i < 10; i++)
      step(1'b0, (i >= 3), (i < 3), "var.rise3");
    for (int i = 0; i < 10; i++)
      step(1'b1, !(i >= 2), (i < 2), "var.fall2");
    step(1'b0, 1'b0, 1'b1, "var.midchg.sched");
    rise_dly = 8'd9;
    for (int i = 1; i < 6; i++)
      step(1'b0, (i >= 3), (i < 3), "var.midchg");
    fall_dly = 8'd0;
    step(1'b1, 1'b0, 1'b0, "var.fall0");
    rise_dly = 8'd255;
    for (int i = 0; i < 257; i++)
      step(1'b0, (i >= 255), (i < 255), "var.rise255");
`endif

    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard.drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/not_u_delay.md
# not_u_delay

Clocked, synthesizable inverter with separate rise and fall propagation delays counted in clock cycles. Inertial behaviour: input pulses shorter than the applicable delay are filtered out. It models a delayed "not" primitive for timing-accurate signal paths, such as delay-line and glitch-filter stages feeding downstream logic in the same clock domain.

## Interface
- `DLY_W`, default 8: width of the delay counter and of the delay ports.
- `RISE_DLY`, default 11: cycles for an out 0→1 transition. Used when `NOT_U_VAR_DLY_EN` is undefined.
- `FALL_DLY`, default 0: cycles for an out 1→0 transition. Used when `NOT_U_VAR_DLY_EN` is undefined.
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in`, input, 1: data input, synchronous to `clk`.
- `rise_dly`, input, DLY_W: runtime rise delay. Present only with `NOT_U_VAR_DLY_EN`.
- `fall_dly`, input, DLY_W: runtime fall delay. Present only with `NOT_U_VAR_DLY_EN`.
- `out`, output, 1: delayed inverse of `in`.
- `pending`, output, 1: a transition of `out` is scheduled but not yet applied.

## Operation
- Target value: `tgt = ~in`, sampled each rising edge.
- State: `out` register, `pending` flag, down-counter `cnt` (DLY_W bits), `pend_val` (scheduled value).
- Idle, with `pending` = 0 and `tgt == out`: nothing changes.
- Schedule: when idle and the sampled `tgt != out`:
  - Select delay D: rise delay if `tgt` = 1, fall delay if `tgt` = 0.
  - If D = 0, set `out <= tgt` on this edge; `pending` stays 0.
  - Otherwise set `pending <= 1`, `pend_val <= tgt`, `cnt <= D-1`.
- Countdown: while `pending` = 1 and the sampled `tgt == pend_val`:
  - If `cnt` = 0, set `out <= pend_val` and `pending <= 0`.
  - Otherwise `cnt` decrements.
- Cancel (inertial): while `pending` = 1 and the sampled `tgt != pend_val`, `tgt` equals `out` again. Clear `pending`; `out` is unchanged and no glitch propagates.
- Delay values are captured at scheduling. Changing `rise_dly`/`fall_dly` mid-countdown does not affect the in-flight transition.
- D = 2^DLY_W − 1 is legal. No saturation or wrap issues, because `cnt` only decrements to 0.
- 2-state logic only; X on `in` is not modeled.

## Timing
- Reset, asynchronous on `rst_n` low: `out` = 0, `pending` = 0, `cnt` = 0, `pend_val` = 0. This is the steady state for `in` = 1.
- Latency: `out` updates on the (D+1)-th consecutive rising edge that samples the new `in` value. The first such edge counts as edge 1.
  - D = 0 gives exactly one register stage.
- Minimum pulse passed: an `in` level must be held for D+1 consecutive sampled edges; shorter pulses are absorbed.
- `pending` asserts on the scheduling edge and deasserts on the edge that updates `out` or cancels.
- Reset asserted mid-countdown discards the scheduled transition immediately.
- After release, if `in` = 0, a rise is scheduled from the first edge.
- Back-to-back transitions: a new transition can be scheduled on the edge after `out` updates. That is the first edge at which `pending` = 0 and `tgt != out`.

## Configuration
- `NOT_U_VAR_DLY_EN` defined:
  - Ports `rise_dly`/`fall_dly` exist and supply D, sampled at scheduling.
  - Parameters `RISE_DLY`/`FALL_DLY` are ignored.
- `NOT_U_VAR_DLY_EN` undefined:
  - The ports are absent; D comes from `RISE_DLY`/`FALL_DLY`.
  - Otherwise identical behaviour and timing.

## Test plan
- Reset with `in` = 1, then drop `in` to 0 at edge 1 (RISE_DLY = 11, FALL_DLY = 0) → `out` = 0 through edge 11, `out` = 1 at edge 12; `pending` high edges 1–11.
- With `out` = 1, raise `in` to 1 (FALL_DLY = 0) → `out` = 0 on the first sampling edge; `pending` never asserts.
- RISE_DLY = 11: `in` low for 5 cycles then back high → `out` stays 0 throughout; `pending` clears on the return edge.
- Assert `rst_n` low at cycle 6 of an 11-cycle rise countdown → `out` = 0 and `pending` = 0 immediately. After release with `in` = 0, `out` rises 12 edges later.
- `NOT_U_VAR_DLY_EN`, `rise_dly` = 3, `fall_dly` = 2: toggle `in` 1→0→1 holding each level 10 cycles → `out` rises on the 4th edge, falls on the 3rd edge. Changing `rise_dly` to 9 mid-countdown has no effect on that rise.
- `NOT_U_VAR_DLY_EN`, `rise_dly` = 255 → `out` rises on edge 256; no counter wrap.
